// File: rtl/hub75_blank_timer_pkg.sv
// Shared FSM encoding and counter sizing for the HUB75 blanking timer.
package hub75_blank_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ON   = 2'd2,
        ST_OFF  = 2'd3
    } state_t;

    localparam int LEN_W = 8;

    // Wide enough for a full 8-bit length shifted by the top plane index.
    function automatic int cnt_width(input int n_planes);
        return LEN_W + n_planes;
    endfunction

endpackage

// File: rtl/hub75_onehot_prio_enc.sv
// Priority encoder: index of the highest set bit, all-zero input maps to 0.
// Purely combinational, no handshake.
module hub75_onehot_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    // Later (higher) bits overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/hub75_blank_timer.sv
// Drives panel OE/blank for (on<<plane, off<<plane) cycles per go strobe; 1-cycle load latency.
// blank_rdy is low for the whole window; a go while busy is dropped and flagged in err_go_busy.
module hub75_blank_timer
    import hub75_blank_timer_pkg::*;
#(
    parameter int N_PLANES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PLANES-1:0] blank_plane,
    input  logic                blank_go,
    output logic                blank_rdy,
    input  logic [LEN_W-1:0]    cfg_on_len,
    input  logic [LEN_W-1:0]    cfg_off_len,
    input  logic                cfg_enable,
    output logic                phy_blank,
    output logic                err_go_busy
);

    localparam int CNT_W = cnt_width(N_PLANES);
    localparam int IDX_W = $clog2(N_PLANES);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [N_PLANES-1:0] plane_q, plane_nxt;
    logic [IDX_W-1:0]    plane_idx;
    logic [CNT_W-1:0]    on_ld, off_ld;

    hub75_onehot_prio_enc #(
        .N     (N_PLANES),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .onehot (plane_q),
        .idx    (plane_idx)
    );

    assign on_ld     = CNT_W'(cfg_on_len) << plane_idx;
    assign off_ld    = CNT_W'(cfg_off_len) << plane_idx;
    assign blank_rdy = (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        plane_nxt = plane_q;
        unique case (state)
            ST_IDLE: begin
                if (blank_go) begin
                    plane_nxt = blank_plane;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Zero-length phases are skipped entirely rather than costing a cycle.
                if (on_ld != '0) begin
                    cnt_nxt   = on_ld;
                    state_nxt = ST_ON;
                end else if (off_ld != '0) begin
                    cnt_nxt   = off_ld;
                    state_nxt = ST_OFF;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ON: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (off_ld != '0) begin
                        cnt_nxt   = off_ld;
                        state_nxt = ST_OFF;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OFF: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            plane_q     <= '0;
            phy_blank   <= 1'b1;
            err_go_busy <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            plane_q     <= plane_nxt;
            // Registered from the next state so the unblanked run lines up with ST_ON exactly.
            phy_blank   <= ~((state_nxt == ST_ON) & cfg_enable);
            err_go_busy <= err_go_busy | (blank_go & ~blank_rdy);
        end
    end

endmodule

// File: tb/tb_hub75_blank_timer.sv
// Randomized and directed check of hub75_blank_timer against a cycle-window reference model.
module tb_hub75_blank_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] blank_plane;
    logic       blank_go;
    logic       blank_rdy;
    logic [7:0] cfg_on_len;
    logic [7:0] cfg_off_len;
    logic       cfg_enable;
    logic       phy_blank;
    logic       err_go_busy;

    hub75_blank_timer #(.N_PLANES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .blank_plane (blank_plane),
        .blank_go    (blank_go),
        .blank_rdy   (blank_rdy),
        .cfg_on_len  (cfg_on_len),
        .cfg_off_len (cfg_off_len),
        .cfg_enable  (cfg_enable),
        .phy_blank   (phy_blank),
        .err_go_busy (err_go_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: absolute cycle numbers of the current window.
    int cyc      = 0;
    int busy_end = 0;
    int on_start = 1;
    int on_end   = 0;
    bit err_exp  = 0;
    bit en_prev  = 0;
    bit chk_on   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int top_bit(input logic [7:0] pl);
        for (int i = 7; i >= 0; i--) begin
            if (pl[i]) return i;
        end
        return 0;
    endfunction

    // Advance one clock: update the model from the inputs of this cycle, then check the next one.
    task automatic step();
        int on_n, off_n, sh;
        if (rst) begin
            busy_end = 0;
            on_start = 1;
            on_end   = 0;
            err_exp  = 0;
        end else if (blank_go) begin
            if (cyc >= busy_end) begin
                sh       = top_bit(blank_plane);
                on_n     = int'(cfg_on_len) * (1 << sh);
                off_n    = int'(cfg_off_len) * (1 << sh);
                on_start = cyc + 2;
                on_end   = cyc + 1 + on_n;
                busy_end = cyc + 2 + on_n + off_n;
            end else begin
                err_exp = 1;
            end
        end
        en_prev = cfg_enable;
        @(posedge clk);
        #1;
        cyc++;
        if (chk_on) begin
            chk("rdy", int'(blank_rdy), int'(cyc >= busy_end));
            chk("blank", int'(phy_blank),
                int'(!(cyc >= on_start && cyc <= on_end && en_prev)));
            chk("err", int'(err_go_busy), int'(err_exp));
        end
    endtask

    // One window from a go strobe; optional busy go at offset poke, optional enable jitter.
    task automatic window(input logic [7:0] pl, input int exp_lat, input int exp_low,
                          input int poke, input bit jitter, input string tag);
        int t0, low;
        t0          = cyc;
        low         = 0;
        blank_plane = pl;
        blank_go    = 1'b1;
        do begin
            step();
            if (!phy_blank) low++;
            blank_go = (poke > 0 && (cyc - t0) == poke);
            if (blank_go) blank_plane = 8'hFF;
            if (jitter) cfg_enable = ($urandom_range(0, 3) != 0);
        end while (!blank_rdy && (cyc - t0) < 40000);
        blank_go = 1'b0;
        chk({tag, "_lat"}, cyc - t0, exp_lat);
        if (exp_low >= 0) chk({tag, "_low"}, low, exp_low);
    endtask

    initial begin
        int on_r, off_r, gap;
        logic [7:0] pl_r;
        rst         = 1'b1;
        blank_plane = '0;
        blank_go    = 1'b0;
        cfg_on_len  = 8'd0;
        cfg_off_len = 8'd0;
        cfg_enable  = 1'b1;
        step();
        chk_on = 1;
        step();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) step();

        cfg_on_len = 8'd4; cfg_off_len = 8'd2;
        window(8'b0000_0001, 8, 4, 0, 0, "lsb");
        window(8'b1000_0000, 770, 512, 0, 0, "msb");

        cfg_on_len = 8'd0; cfg_off_len = 8'd3;
        window(8'b0000_0100, 14, 0, 0, 0, "on0");
        cfg_off_len = 8'd0;
        window(8'b0000_0100, 2, 0, 0, 0, "both0");

        cfg_on_len = 8'd3; cfg_off_len = 8'd1;
        window(8'b0000_0110, 18, 12, 0, 0, "multihot");

        cfg_on_len = 8'd255; cfg_off_len = 8'd0;
        window(8'b1000_0000, 32642, 32640, 0, 0, "max");

        // Go while busy: window unchanged, error sticky
        cfg_on_len = 8'd6; cfg_off_len = 8'd3;
        window(8'b0000_0010, 20, 12, 4, 0, "busygo");
        for (int i = 0; i < 5; i++) step();
        chk("err_sticky", int'(err_go_busy), 1);

        // Reset while in the OFF phase
        cfg_on_len = 8'd2; cfg_off_len = 8'd8;
        blank_plane = 8'b0000_0001;
        blank_go = 1'b1;
        step();
        blank_go = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("off_rdy_busy", int'(blank_rdy), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rdy", int'(blank_rdy), 1);
        chk("rst_blank", int'(phy_blank), 1);
        chk("rst_err", int'(err_go_busy), 0);
        step();

        cfg_enable = 1'b0; cfg_on_len = 8'd5; cfg_off_len = 8'd3;
        window(8'b0000_1000, 66, 0, 0, 0, "disabled");
        cfg_enable = 1'b1;

        // Randomized windows, enable jitter and occasional busy go
        for (int k = 0; k < 30; k++) begin
            on_r  = $urandom_range(0, 20);
            off_r = $urandom_range(0, 20);
            pl_r  = 8'($urandom_range(0, 63));
            cfg_on_len  = 8'(on_r);
            cfg_off_len = 8'(off_r);
            window(pl_r, 2 + (on_r + off_r) * (1 << top_bit(pl_r)), -1,
                   ($urandom_range(0, 3) == 0) ? 3 : 0, 1, "rand");
            cfg_enable = 1'b1;
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
